// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Connects the instruction-fetch port and the data port of the single-cycle
//   datapath to one single-ported, variable-latency RAM. One access runs at a
//   time, and data wins over instruction when both are pending. Each request
//   is latched for the whole access. Completion produces a one-cycle
//   ihit/dhit pulse with registered load data. A wait-cycle watchdog latches
//   err and parks the block until reset.
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   iREN, iaddr          instruction read request (held until ihit)
//   dREN, dWEN, daddr,   data read/write request (held until dhit)
//   dstore
//   ihit, dhit           one-cycle completion pulses
//   iload, dload         last fetched instruction / last loaded data word
//   ramREN, ramWEN,      RAM strobes, word address, write data
//   ramaddr, ramstore
//   ramload, ramrdy      RAM read data and completion
//   err                  sticky timeout flag
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramrdy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, IREQ, DREQ, RESP, ERR} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_ihit, r_dhit, r_err;
  logic        r_ramREN, r_ramWEN;
  logic [31:0] r_ramaddr, r_ramstore;
  logic [31:0] r_iload, r_dload;

  // The registered strobe/address/store outputs double as the latched copy
  // of the request, so no separate request holding registers are needed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_err      <= 1'b0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_iload    <= '0;
      r_dload    <= '0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dREN || dWEN) begin
            // read+write together is served as a write
            r_state    <= DREQ;
            r_cnt      <= '0;
            r_ramWEN   <= dWEN;
            r_ramREN   <= ~dWEN;
            r_ramaddr  <= {daddr[31:2], 2'b00};
            r_ramstore <= dstore;
          end else if (iREN) begin
            r_state    <= IREQ;
            r_cnt      <= '0;
            r_ramREN   <= 1'b1;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= {iaddr[31:2], 2'b00};
            r_ramstore <= '0;
          end
        end
        IREQ, DREQ: begin
          if (ramrdy) begin
            if (r_state == IREQ) begin
              r_iload <= ramload;
              r_ihit  <= 1'b1;
            end else begin
              if (r_ramREN) r_dload <= ramload;
              r_dhit <= 1'b1;
            end
            r_state    <= RESP;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
          end else if (r_cnt == TO) begin
            // RAM has been silent for TIMEOUT wait cycles plus this one
            r_state    <= ERR;
            r_err      <= 1'b1;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP:    r_state <= IDLE;  // turnaround: requester drops its request
        ERR:     r_state <= ERR;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ihit     = r_ihit;
  assign dhit     = r_dhit;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign ramREN   = r_ramREN;
  assign ramWEN   = r_ramWEN;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        CLK = 1'b0, nRST;
  logic        iREN, dREN, dWEN, ramrdy;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramrdy(ramrdy), .err(err)
  );

  int n_tests = 0, n_fail = 0, hits_seen = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: ready after lat_cur strobe cycles, never when hang is set
  logic [31:0] mem [0:255];
  int          wcnt = 0, lat_cur = 1;
  bit          hang = 0, force_rdy = 0;
  logic [31:0] cap_addr, cap_store;
  logic        cap_ren, cap_wen;

  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      wcnt++;
      if (wcnt == 1) begin
        cap_addr = ramaddr; cap_store = ramstore; cap_ren = ramREN; cap_wen = ramWEN;
      end
      if (!hang && wcnt >= lat_cur) begin
        ramrdy  = 1'b1;
        ramload = ramREN ? mem[ramaddr[9:2]] : 32'hBAD0BAD0;
        if (ramWEN) mem[ramaddr[9:2]] = ramstore;
      end else begin
        ramrdy = 1'b0; ramload = 32'hBAD0BAD0;
      end
    end else begin
      wcnt = 0; ramrdy = force_rdy; ramload = 32'hBAD0BAD0;
    end
  end

  // scoreboard: expected completions in order
  typedef struct { bit is_d; bit wr; logic [31:0] load; int t0; int lat; } exp_t;
  exp_t sbq[$];
  exp_t e;

  always @(negedge CLK) begin
    if (ramREN && ramWEN) begin
      n_tests++; n_fail++; $display("FAIL strobe_overlap: both RAM strobes high at cycle %0d", cyc);
    end
    if (ihit && dhit) begin
      n_tests++; n_fail++; $display("FAIL hit_overlap: ihit and dhit both high at cycle %0d", cyc);
    end
    if (ihit || dhit) begin
      hits_seen++;
      if (sbq.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL unexpected_hit: ihit=%b dhit=%b want none", ihit, dhit);
      end else begin
        e = sbq.pop_front();
        chk("hit_kind_dhit", {31'd0, dhit}, {31'd0, e.is_d});
        if (e.is_d) chk("dload", dload, e.load);
        else        chk("iload", iload, e.load);
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic wait_hits(input int target, input int budget, input string name);
    int k = 0;
    while (hits_seen < target && k < budget) begin
      @(negedge CLK); #1; k++;
    end
    if (hits_seen < target) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no hit within %0d cycles (hits %0d want %0d)", name, budget, hits_seen, target);
    end
  endtask

  typedef struct {
    bit is_d; bit wen; logic [31:0] addr; logic [31:0] store;
    int lat; logic [31:0] exp_load; logic [31:0] exp_raddr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int h0 = hits_seen;
    @(negedge CLK);
    lat_cur = v.lat;
    if (v.is_d) begin dREN = 1'b1; dWEN = v.wen; daddr = v.addr; dstore = v.store; end
    else begin iREN = 1'b1; iaddr = v.addr; end
    sbq.push_back('{v.is_d, v.wen, v.exp_load, cyc, v.lat + 1});
    wait_hits(h0 + 1, 40, "vec_hit");
    iREN = 0; dREN = 0; dWEN = 0;
    chk("ramaddr", cap_addr, v.exp_raddr);
    chk("ramWEN", {31'd0, cap_wen}, {31'd0, v.wen});
    chk("ramREN", {31'd0, cap_ren}, {31'd0, v.is_d ? !v.wen : 1'b1});
    if (v.wen) chk("ramstore", cap_store, v.store);
    @(negedge CLK);
  endtask

  vec_t vt[8];
  int   h0, k;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A5A0000 + i;
    mem[8'h11] = 32'h3C01ABCD;
    mem[8'h40] = 32'h11112222;
    //         is_d wen addr          store         lat exp_load       exp_raddr
    vt[0] = '{0, 0, 32'h00000046, 32'h0,        1, 32'h3C01ABCD, 32'h00000044};
    vt[1] = '{1, 0, 32'h00000100, 32'h0,        2, 32'h11112222, 32'h00000100};
    vt[2] = '{1, 1, 32'h00000200, 32'hDEADBEEF, 3, 32'h11112222, 32'h00000200};
    vt[3] = '{1, 0, 32'h00000203, 32'h0,        1, 32'hDEADBEEF, 32'h00000200};
    vt[4] = '{1, 1, 32'h0000030C, 32'hCAFEF00D, 2, 32'hDEADBEEF, 32'h0000030C};
    vt[5] = '{0, 0, 32'h0000030C, 32'h0,        1, 32'hCAFEF00D, 32'h0000030C};
    vt[6] = '{0, 0, 32'h000000FF, 32'h0,        4, 32'h5A5A003F, 32'h000000FC};
    vt[7] = '{0, 0, 32'h00000000, 32'h0,    TO + 1, 32'h5A5A0000, 32'h00000000};

    nRST = 0; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramrdy = 0; ramload = 0;
    #2;
    chk("rst_flags", {27'd0, ihit, dhit, ramREN, ramWEN, err}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_loads", iload | dload, 32'd0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1;

    // table: basic reads, writes, read+write, TIMEOUT+1 boundary latency
    for (int i = 0; i < 8; i++) begin
      if (vt[i].is_d && vt[i].wen) begin
        // a data write must leave dload intact after its hit
        run_vec(vt[i]);
        chk("dload_after_write", dload, vt[i].exp_load);
      end else run_vec(vt[i]);
    end
    chk("iload_stable", iload, 32'h5A5A0000);

    // ramrdy while idle is ignored
    force_rdy = 1; h0 = hits_seen;
    repeat (4) @(negedge CLK);
    force_rdy = 0;
    chk("idle_rdy_no_hit", hits_seen, h0);

    // simultaneous requests: data first, then instruction
    @(negedge CLK);
    lat_cur = 3; h0 = hits_seen;
    iREN = 1; iaddr = 32'h48; dREN = 1; daddr = 32'h100;
    sbq.push_back('{1, 0, 32'h11112222, cyc, 4});
    sbq.push_back('{0, 0, 32'h5A5A0012, cyc, 9});
    wait_hits(h0 + 1, 20, "simul_d");
    dREN = 0;
    wait_hits(h0 + 2, 20, "simul_i");
    iREN = 0;
    chk("simul_i_addr", cap_addr, 32'h48);
    @(negedge CLK);

    // request inputs changed mid-access are ignored
    @(negedge CLK);
    lat_cur = 3; h0 = hits_seen;
    dREN = 1; daddr = 32'h104;
    sbq.push_back('{1, 0, 32'h5A5A0041, cyc, 4});
    @(negedge CLK);
    daddr = 32'h200; dWEN = 1; dstore = 32'h0;
    @(negedge CLK); #1;
    chk("latched_addr", ramaddr, 32'h104);
    chk("latched_rd", {30'd0, ramREN, ramWEN}, 32'd2);
    wait_hits(h0 + 1, 20, "latched_hit");
    dREN = 0; dWEN = 0;
    @(negedge CLK);

    // reset in the middle of a long access
    @(negedge CLK);
    lat_cur = 5; h0 = hits_seen;
    dREN = 1; daddr = 32'h100;
    repeat (3) @(negedge CLK);
    #2 nRST = 0;
    #1;
    chk("midrst_flags", {27'd0, ihit, dhit, ramREN, ramWEN, err}, 32'd0);
    chk("midrst_ramaddr", ramaddr, 32'd0);
    chk("midrst_loads", iload | dload, 32'd0);
    dREN = 0;
    @(negedge CLK); @(negedge CLK);
    nRST = 1;
    repeat (6) @(negedge CLK);
    chk("midrst_no_hit", hits_seen, h0);
    run_vec(vt[0]);

    // watchdog
    @(negedge CLK);
    hang = 1; lat_cur = 1;
    dREN = 1; daddr = 32'h100; h0 = cyc;
    k = 0;
    while (!err && k < 20) begin @(negedge CLK); #1; k++; end
    chk("err_cycle", cyc - h0, TO + 2);
    chk("err_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("err_ramaddr", ramaddr, 32'd0);
    dREN = 0; hang = 0;
    @(negedge CLK);
    h0 = hits_seen;
    iREN = 1; iaddr = 32'h46;
    repeat (8) @(negedge CLK);
    #1;
    chk("err_no_hit", hits_seen, h0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_no_strobe", {31'd0, ramREN}, 32'd0);
    iREN = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates between the instruction-fetch and data-access requests of the single-cycle datapath (PC/imem read and control unit's dmemREN/dmemWEN/dmemaddr/dmemstore) and one single-ported, variable-latency RAM. It serializes the two request streams with data priority and latches each request for its whole access. It returns one-cycle hit pulses with registered load data, which the datapath uses to stall PC update and register writeback. A wait-cycle watchdog flags a hung RAM.

## Interface
Parameters:
- TIMEOUT, 15, maximum RAM wait cycles per access before error (1..255)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction byte address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  32  data byte address
- dstore  in  32  data write value
- ihit  out  1  one-cycle pulse: instruction access complete
- dhit  out  1  one-cycle pulse: data access complete
- iload  out  32  last fetched instruction word
- dload  out  32  last loaded data word
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM word address (byte address with bits [1:0] = 0)
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramrdy = 1
- ramrdy  in  1  RAM access complete this cycle
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, IREQ, DREQ, RESP, ERR.
- IDLE: sample requests. If dREN or dWEN is high, latch daddr, dstore, and wr = dWEN, then go to DREQ. Otherwise, if iREN is high, latch iaddr and go to IREQ. Otherwise stay in IDLE.
- Data wins over instruction when both are pending. The instruction request stays pending and is served after the data access completes.
- dREN and dWEN both high: treated as a write (ramWEN = 1, ramREN = 0).
- IREQ: ramREN = 1, ramaddr = {latched iaddr[31:2], 2'b00}.
- DREQ: ramWEN = wr, ramREN = ~wr, ramaddr = {latched daddr[31:2], 2'b00}, ramstore = latched dstore.
- RAM strobes are low in IDLE, RESP, and ERR. ramaddr and ramstore are 0 when not in IREQ or DREQ.
- In IREQ or DREQ with ramrdy = 1: register ramload into iload (IREQ) or, for a read in DREQ, into dload; set the matching hit for the next cycle; go to RESP. A write leaves dload unchanged.
- RESP: exactly one of ihit/dhit is 1. No requests are sampled. Next state is IDLE. This turnaround lets the requester drop or change its request.
- Wait counter: cleared on entry to IREQ or DREQ and incremented on each cycle ramrdy = 0. When it reaches TIMEOUT with ramrdy still 0, go to ERR.
- ERR: err = 1, all strobes low, no hits. Remain in ERR until reset.
- ramrdy outside IREQ/DREQ is ignored.
- Request inputs changing during IREQ/DREQ are ignored because the latched copies are used.

## Timing
- Reset values: ihit = dhit = 0, iload = dload = 0, ramREN = ramWEN = 0, ramaddr = ramstore = 0, err = 0, state IDLE, counter 0.
- Reset mid-access aborts immediately with no hit.
- Request sampled in IDLE at edge N. RAM strobes are driven from cycle N+1.
- ramrdy high in cycle M: hit and updated load are visible in cycle M+1 (RESP). IDLE in cycle M+2.
- Minimum latency: request to hit is 2 cycles (ramrdy in the first REQ cycle). A back-to-back request is sampled 3 cycles after the previous one.
- iload/dload are stable between their own completed reads.
- Timeout: with ramrdy never asserted, err rises TIMEOUT+1 cycles after the REQ state is entered.

## Test plan
- Instruction read: iREN = 1, iaddr = 0x00000046, RAM returns 0x3C01ABCD with ramrdy in the first REQ cycle -> ramaddr = 0x00000044, ihit pulses 1 cycle at request+2, iload = 0x3C01ABCD.
- Simultaneous requests: iREN = dREN = 1, daddr = 0x100, RAM latency 3 -> DREQ served first, dhit at request+4; the IREQ access begins afterward; ihit follows; no overlapping strobes.
- Write: dWEN = 1, daddr = 0x200, dstore = 0xDEADBEEF -> ramWEN = 1, ramREN = 0, ramstore = 0xDEADBEEF until ramrdy; dhit pulses; dload unchanged.
- Read+write together: dREN = dWEN = 1 -> ramWEN = 1, ramREN = 0.
- Timeout: TIMEOUT = 4, dREN = 1, ramrdy held 0 -> err = 1 at cycle 5 of DREQ; strobes drop; later requests get no hit until nRST.
- Mid-access reset: assert nRST = 0 during a 5-cycle RAM wait -> all outputs 0 asynchronously, no hit; a fresh request after release completes normally.
